game_packet_tx: RTL



---
 rtl/game_packet_tx_pkg.sv | 17 +
 rtl/game_packet_tx_fifo.sv | 57 +++++
 rtl/game_packet_tx.sv | 98 +++++++++
 3 files changed

// File: rtl/game_packet_tx_pkg.sv
// Shared game-link definitions: transmit FSM states and packet header codes
// used by both the encoder here and the receive-side decoder.
package common_enums;

  typedef enum logic [2:0] {
    PTX_IDLE,
    PTX_SEND,
    PTX_WAIT_START,
    PTX_WAIT_DONE,
    PTX_GAP
  } pkt_tx_state_t;

  localparam logic [1:0] PKT_HDR_SETUP = 2'b10;
  localparam logic [1:0] PKT_HDR_MOVE  = 2'b00;
  localparam int         PKT_W         = 16;

endpackage

// File: rtl/game_packet_tx_fifo.sv
// Synchronous 16-bit packet queue with a registered read port; a push into a
// full queue is honoured only when a pop happens in the same cycle.
module pkt_fifo
  import common_enums::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [PKT_W-1:0]               push_data,
  input  logic                           pop,
  output logic [PKT_W-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [PKT_W-1:0] pop_data_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pop_data_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        pop_data_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = pop_data_q;
  assign count    = count_q;

endmodule

// File: rtl/game_packet_tx.sv
// Encodes setup/move events into 16-bit packets, queues them and paces them
// out to the UART transmitter one at a time with a post-packet idle gap.
module game_packet_tx
  import common_enums::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              setup_req,
  input  logic                              setup_color,
  input  logic [1:0]                        setup_mode,
  input  logic                              move_req,
  input  logic [11:0]                       move_packet,
  input  logic                              tx_busy,
  output logic                              data_valid,
  output logic [15:0]                       data_in_tx,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              drop
);

  localparam int TMAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  pkt_tx_state_t    state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             data_valid_q, data_valid_d;
  logic             drop_q, drop_d;
  logic             push, pop, fifo_full, fifo_empty, req;
  logic [PKT_W-1:0] push_data;

  // Setup wins a same-cycle collision; the losing move is reported as a drop.
  always_comb begin
    req       = setup_req || move_req;
    push      = req;
    push_data = setup_req ? {PKT_HDR_SETUP, setup_color, setup_mode, 11'b0}
                          : {PKT_HDR_MOVE, move_packet, 2'b00};
    drop_d    = (setup_req && move_req) || (req && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PTX_IDLE;
      timer_q      <= '0;
      data_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      data_valid_q <= data_valid_d;
      drop_q       <= drop_d;
    end
  end

  // One timer serves both the start timeout and the inter-packet gap.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      PTX_IDLE:       if (!fifo_empty) state_d = PTX_SEND;
      PTX_SEND:       state_d = PTX_WAIT_START;
      PTX_WAIT_START: begin
        if (tx_busy)                               state_d = PTX_WAIT_DONE;
        else if (timer_q == TW'(START_TIMEOUT-1))  state_d = PTX_GAP;
        else                                       timer_d = timer_q + 1'b1;
      end
      PTX_WAIT_DONE:  if (!tx_busy) state_d = PTX_GAP;
      PTX_GAP: begin
        if (timer_q == TW'(GAP_CYCLES-1)) state_d = PTX_IDLE;
        else                              timer_d = timer_q + 1'b1;
      end
      default:        state_d = PTX_IDLE;
    endcase
  end

  always_comb begin
    pop          = (state_q == PTX_IDLE) && !fifo_empty;
    data_valid_d = pop;
  end

  pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (data_in_tx),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign data_valid = data_valid_q;
  assign drop       = drop_q;

endmodule
